// File: rtl/cla_pkg.sv
// Shared constants and operand type for the 64-bit carry-lookahead adder.
// Optional feature in the top: define CLA64_INREG_EN to register A/B/c
// ahead of the adder.
package cla_pkg;

   // Datapath width and lookahead block width.
   localparam int unsigned CLA_W    = 64;
   localparam int unsigned CLA_BLK  = 4;

   // 16 four-bit blocks, grouped four at a time into 16-bit groups.
   localparam int unsigned CLA_NBLK = CLA_W / CLA_BLK;
   localparam int unsigned CLA_NGRP = CLA_NBLK / CLA_BLK;

   typedef logic [CLA_W-1:0] operand_t;

endpackage

// File: rtl/cla_4bit.sv
// Four-wide carry-lookahead unit. It is used for 4-bit blocks, for the
// 16-bit group level and for the top level across the four groups.
// Each output has its own assign so that the carry network can be
// levelised per signal.
module cla_4bit
   import cla_pkg::*;
(
   input  logic [CLA_BLK-1:0] p,
   input  logic [CLA_BLK-1:0] g,
   input  logic               cin,
   output logic [CLA_BLK-1:1] carries,
   output logic               block_p,
   output logic               block_g
);

   assign carries[1] = g[0]
                     | (p[0] & cin);

   assign carries[2] = g[1]
                     | (p[1] & g[0])
                     | (p[1] & p[0] & cin);

   assign carries[3] = g[2]
                     | (p[2] & g[1])
                     | (p[2] & p[1] & g[0])
                     | (p[2] & p[1] & p[0] & cin);

   assign block_p = &p;

   assign block_g = g[3]
                  | (p[3] & g[2])
                  | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_64bits.sv
// 64-bit registered carry-lookahead adder: S = A + B + c (mod 2^64), plus
// the 64-bit group propagate P and group generate G.
// The carry hierarchy has three levels: 16 four-bit blocks, 4 groups of
// 16 bits, and one top lookahead across the groups.
// When CLA64_INREG_EN is defined, A/B/c are registered first. This gives a
// latency of 2 instead of 1.
module cla_64bits
   import cla_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [CLA_W-1:0] A,
   input  logic [CLA_W-1:0] B,
   input  logic             c,
   output logic [CLA_W-1:0] S,
   output logic             P,
   output logic             G
);

   operand_t a_in;
   operand_t b_in;
   logic     c_in;

`ifdef CLA64_INREG_EN
   // Register the operands before the adder. Reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_in <= '0;
         b_in <= '0;
         c_in <= 1'b0;
      end else begin
         a_in <= A;
         b_in <= B;
         c_in <= c;
      end
   end
`else
   // The operands feed the adder directly.
   always_comb begin
      a_in = A;
      b_in = B;
      c_in = c;
   end
`endif

   // Per-bit propagate and generate.
   operand_t bit_p;
   operand_t bit_g;

   assign bit_p = a_in ^ b_in;
   assign bit_g = a_in & b_in;

   // Lookahead hierarchy signals.
   logic [CLA_NBLK-1:0] blk_p;
   logic [CLA_NBLK-1:0] blk_g;
   logic [CLA_NBLK-1:0] blk_c;
   logic [CLA_BLK-1:1]  blk_carries [CLA_NBLK];

   logic [CLA_NGRP-1:0] grp_p;
   logic [CLA_NGRP-1:0] grp_g;
   logic [CLA_NGRP-1:0] grp_c;
   logic [CLA_BLK-1:1]  grp_carries [CLA_NGRP];

   logic [CLA_BLK-1:1]  top_carries;
   logic                top_p;
   logic                top_g;

   operand_t carry;
   operand_t sum_next;

   // Level 1: one unit per 4-bit slice of the operands.
   for (genvar b = 0; b < CLA_NBLK; b++) begin : g_blk
      cla_4bit u_blk (
         .p       (bit_p[CLA_BLK*b +: CLA_BLK]),
         .g       (bit_g[CLA_BLK*b +: CLA_BLK]),
         .cin     (blk_c[b]),
         .carries (blk_carries[b]),
         .block_p (blk_p[b]),
         .block_g (blk_g[b])
      );

      // Carry into the block's lowest bit, then the lookahead carries
      // into its upper three bits.
      assign carry[CLA_BLK*b]                 = blk_c[b];
      assign carry[CLA_BLK*b+1 +: CLA_BLK-1]  = blk_carries[b];
   end

   // Level 2: one unit per 16-bit group, fed by the four block P/G pairs.
   for (genvar k = 0; k < CLA_NGRP; k++) begin : g_grp
      cla_4bit u_grp (
         .p       (blk_p[CLA_BLK*k +: CLA_BLK]),
         .g       (blk_g[CLA_BLK*k +: CLA_BLK]),
         .cin     (grp_c[k]),
         .carries (grp_carries[k]),
         .block_p (grp_p[k]),
         .block_g (grp_g[k])
      );

      // Carry into each 4-bit block of this group.
      assign blk_c[CLA_BLK*k]                = grp_c[k];
      assign blk_c[CLA_BLK*k+1 +: CLA_BLK-1] = grp_carries[k];
   end

   // Level 3: lookahead across the four groups. Its block_g is the
   // carry out of bit 63 with c = 0, because c enters only through
   // the carries.
   cla_4bit u_top (
      .p       (grp_p),
      .g       (grp_g),
      .cin     (c_in),
      .carries (top_carries),
      .block_p (top_p),
      .block_g (top_g)
   );

   assign grp_c    = {top_carries, c_in};
   assign sum_next = bit_p ^ carry;

   // Register the sum and the group flags. Reset clears them and
   // discards any work in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         S <= '0;
         P <= 1'b0;
         G <= 1'b0;
      end else begin
         S <= sum_next;
         P <= top_p;
         G <= top_g;
      end
   end

endmodule

// File: tb/tb_cla_64bits.sv
// Self-checking bench for cla_64bits. It uses a scoreboard queue of
// expected results. Latency follows CLA64_INREG_EN.
module tb_cla_64bits;

`ifdef CLA64_INREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] A;
   logic [63:0] B;
   logic        c;
   logic [63:0] S;
   logic        P;
   logic        G;

   typedef struct {
      logic [63:0] s;
      logic        p;
      logic        g;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   cla_64bits dut (
      .clk (clk),
      .rst (rst),
      .A   (A),
      .B   (B),
      .c   (c),
      .S   (S),
      .P   (P),
      .G   (G)
   );

   always #5 clk = ~clk;

   // Apply one operand set for one clock and push its expected result.
   // A reset zeroes everything queued, because in-flight results are
   // discarded.
   task automatic drive(input logic r, input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input string tag);
      exp_t        e;
      logic [64:0] full;
      logic [64:0] noc;
      rst = r;
      A   = a;
      B   = b;
      c   = ci;
      if (r) begin
         foreach (sb[i]) begin
            sb[i].s   = '0;
            sb[i].p   = 1'b0;
            sb[i].g   = 1'b0;
            sb[i].tag = {tag, "_flushed"};
         end
         e.s = '0;
         e.p = 1'b0;
         e.g = 1'b0;
      end else begin
         full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
         noc  = {1'b0, a} + {1'b0, b};
         e.s  = full[63:0];
         e.p  = &(a ^ b);
         e.g  = noc[64];
      end
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, '1, '1, 1'b1, $sformatf("reset%0d", i));
         n_checks++;
         if (S !== 64'd0 || P !== 1'b0 || G !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_direct%0d: got S=%h P=%b G=%b, expected all zero", i, S, P, G);
         end
         if (sb.size() >= LAT) begin
            e = sb.pop_front();
            n_checks++;
            if (S !== e.s) begin n_fail++; $display("FAIL %s S: got %h expected %h", e.tag, S, e.s); end
            n_checks++;
            if (P !== e.p) begin n_fail++; $display("FAIL %s P: got %b expected %b", e.tag, P, e.p); end
            n_checks++;
            if (G !== e.g) begin n_fail++; $display("FAIL %s G: got %b expected %b", e.tag, G, e.g); end
         end
      end
   endtask

   task automatic test_directed();
      exp_t        e;
      logic [63:0] va [5];
      logic [63:0] vb [5];
      logic        vc [5];
      va[0] = 64'h000000000000000F; vb[0] = 64'h000000000000000A; vc[0] = 1'b0;
      va[1] = 64'hFFFFFFFFFFFFFFFF; vb[1] = 64'h0000000000000001; vc[1] = 1'b0;
      va[2] = 64'hFFFFFFFFFFFFFFFF; vb[2] = 64'h0000000000000000; vc[2] = 1'b1;
      va[3] = 64'h0FFFFFFFFFFFFFFF; vb[3] = 64'h0000000000000001; vc[3] = 1'b0;
      va[4] = 64'h8000000000000000; vb[4] = 64'h8000000000000000; vc[4] = 1'b1;
      for (int i = 0; i < 5 + LAT - 1; i++) begin
         if (i < 5) drive(1'b0, va[i], vb[i], vc[i], $sformatf("directed%0d", i));
         else       drive(1'b0, 64'd0, 64'd0, 1'b0, "directed_idle");
         if (sb.size() >= LAT) begin
            e = sb.pop_front();
            n_checks++;
            if (S !== e.s) begin n_fail++; $display("FAIL %s S: got %h expected %h", e.tag, S, e.s); end
            n_checks++;
            if (P !== e.p) begin n_fail++; $display("FAIL %s P: got %b expected %b", e.tag, P, e.p); end
            n_checks++;
            if (G !== e.g) begin n_fail++; $display("FAIL %s G: got %b expected %b", e.tag, G, e.g); end
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic [63:0] a;
      logic [63:0] b;
      for (int i = 0; i < 200; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         // Every eighth cycle, make all bits propagate so that P = 1 gets exercised.
         if (i % 8 == 3) b = ~a;
         drive(1'b0, a, b, 1'($urandom_range(0, 1)), $sformatf("b2b%0d", i));
         if (sb.size() >= LAT) begin
            e = sb.pop_front();
            n_checks++;
            if (S !== e.s) begin n_fail++; $display("FAIL %s S: got %h expected %h", e.tag, S, e.s); end
            n_checks++;
            if (P !== e.p) begin n_fail++; $display("FAIL %s P: got %b expected %b", e.tag, P, e.p); end
            n_checks++;
            if (G !== e.g) begin n_fail++; $display("FAIL %s G: got %b expected %b", e.tag, G, e.g); end
         end
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      for (int i = 0; i < 40 + LAT - 1; i++) begin
         if (i == 20) begin
            drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, "midrst");
            n_checks++;
            if (S !== 64'd0 || P !== 1'b0 || G !== 1'b0) begin
               n_fail++;
               $display("FAIL midrst_direct: got S=%h P=%b G=%b, expected all zero", S, P, G);
            end
         end else if (i < 40) begin
            drive(1'b0, {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), $sformatf("mid%0d", i));
         end else begin
            drive(1'b0, 64'd0, 64'd0, 1'b0, "mid_idle");
         end
         if (sb.size() >= LAT) begin
            e = sb.pop_front();
            n_checks++;
            if (S !== e.s) begin n_fail++; $display("FAIL %s S: got %h expected %h", e.tag, S, e.s); end
            n_checks++;
            if (P !== e.p) begin n_fail++; $display("FAIL %s P: got %b expected %b", e.tag, P, e.p); end
            n_checks++;
            if (G !== e.g) begin n_fail++; $display("FAIL %s G: got %b expected %b", e.tag, G, e.g); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
